match_ctrl: RTL and testbench

//  Round/match sequencer for the tug-of-war datapath. Starts each round after a

---
 rtl/match_ctrl.sv | 178 +++++++++++++++++
 tb/tb_match_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// Round/match sequencer for the tug-of-war datapath: random GO delay, first-push
// arbitration with a tie window, round and match scoring. Optional: FALSE_START_EN.
module match_ctrl #(
  parameter int WIN_ROUNDS = 3,
  parameter int MIN_WAIT   = 4,
  parameter int MAX_WAIT   = 32,
  parameter int TIE_WINDOW = 2,
  parameter int SHOW_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen,
  input  logic       rand_bit,
  input  logic       start,
  input  logic       pbl_sy,
  input  logic       pbr_sy,
  output logic       clr,
  output logic       leds_on,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       false_start,
  output logic [3:0] wins_l,
  output logic [3:0] wins_r,
  output logic       match_over,
  output logic       match_right
);

  localparam int CMAX0 = (MAX_WAIT > SHOW_TICKS) ? MAX_WAIT : SHOW_TICKS;
  localparam int CMAX  = (CMAX0 > TIE_WINDOW) ? CMAX0 : TIE_WINDOW;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GO, S_ARB, S_RESULT, S_MATCH_END
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          pbl_q, pbr_q;
  logic          el, er;
  logic          first_right, pend_tie;
  logic          opp_edge, tie_fin;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    el       = pbl_sy & ~pbl_q;
    er       = pbr_sy & ~pbr_q;
    cnt_inc  = cnt + CW'(1);
    // a second press from the side that did not push first, seen in the same ARB cycle
    opp_edge = first_right ? el : er;
    tie_fin  = pend_tie | opp_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pbl_q       <= 1'b0;
      pbr_q       <= 1'b0;
      first_right <= 1'b0;
      pend_tie    <= 1'b0;
      clr         <= 1'b0;
      leds_on     <= 1'b0;
      winrnd      <= 1'b0;
      right       <= 1'b0;
      tie         <= 1'b0;
      false_start <= 1'b0;
      wins_l      <= '0;
      wins_r      <= '0;
      match_over  <= 1'b0;
      match_right <= 1'b0;
    end else begin
      pbl_q  <= pbl_sy;
      pbr_q  <= pbr_sy;
      clr    <= 1'b0;
      winrnd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_WAIT;
            cnt    <= '0;
            wins_l <= '0;
            wins_r <= '0;
            clr    <= 1'b1;
          end
        end
        S_WAIT: begin
`ifdef FALSE_START_EN
          if (el || er) begin
            state       <= S_RESULT;
            cnt         <= '0;
            winrnd      <= 1'b1;
            false_start <= 1'b1;
            tie         <= el & er;
            right       <= el & ~er;
            if (el && !er)
              wins_r <= sat_inc(wins_r);
            else if (er && !el)
              wins_l <= sat_inc(wins_l);
          end else
`endif
          if (slowen) begin
            if (cnt_inc >= CW'(MAX_WAIT) || (cnt_inc >= CW'(MIN_WAIT) && rand_bit)) begin
              state   <= S_GO;
              cnt     <= '0;
              leds_on <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_GO: begin
          if (el || er) begin
            state       <= S_ARB;
            cnt         <= '0;
            first_right <= er & ~el;
            pend_tie    <= el & er;
          end
        end
        S_ARB: begin
          if (cnt == CW'(TIE_WINDOW - 1)) begin
            state       <= S_RESULT;
            cnt         <= '0;
            leds_on     <= 1'b0;
            winrnd      <= 1'b1;
            tie         <= tie_fin;
            right       <= first_right & ~tie_fin;
            false_start <= 1'b0;
            if (!tie_fin) begin
              if (first_right)
                wins_r <= sat_inc(wins_r);
              else
                wins_l <= sat_inc(wins_l);
            end
          end else begin
            cnt <= cnt_inc;
            if (opp_edge)
              pend_tie <= 1'b1;
          end
        end
        S_RESULT: begin
          if (slowen) begin
            if (cnt_inc == CW'(SHOW_TICKS)) begin
              cnt <= '0;
              if (wins_l == 4'(WIN_ROUNDS) || wins_r == 4'(WIN_ROUNDS)) begin
                state       <= S_MATCH_END;
                match_over  <= 1'b1;
                match_right <= (wins_r == 4'(WIN_ROUNDS));
              end else begin
                state <= S_WAIT;
                clr   <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_MATCH_END: begin
          if (start) begin
            state       <= S_WAIT;
            cnt         <= '0;
            wins_l      <= '0;
            wins_r      <= '0;
            clr         <= 1'b1;
            match_over  <= 1'b0;
            match_right <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized self-checking bench for match_ctrl; expectations come from a
// round-level model of the match rules (tick counts, push timings, scores).
module tb_match_ctrl;

  localparam int WR    = 3;
  localparam int MINW  = 4;
  localparam int MAXW  = 32;
  localparam int TW    = 2;
  localparam int SHOW  = 16;
  localparam int NEVER = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slowen = 1'b0, rand_bit = 1'b0, start = 1'b0;
  logic       pbl_sy = 1'b0, pbr_sy = 1'b0;
  logic       clr, leds_on, winrnd, right, tie, false_start;
  logic [3:0] wins_l, wins_r;
  logic       match_over, match_right;

  int unsigned n_pass = 0, n_total = 0;
  int exp_wl = 0, exp_wr = 0;
  bit exp_over = 1'b0;

  match_ctrl #(.WIN_ROUNDS(WR), .MIN_WAIT(MINW), .MAX_WAIT(MAXW),
               .TIE_WINDOW(TW), .SHOW_TICKS(SHOW)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .rand_bit(rand_bit), .start(start),
    .pbl_sy(pbl_sy), .pbr_sy(pbr_sy), .clr(clr), .leds_on(leds_on),
    .winrnd(winrnd), .right(right), .tie(tie), .false_start(false_start),
    .wins_l(wins_l), .wins_r(wins_r), .match_over(match_over),
    .match_right(match_right)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_wl = 0; exp_wr = 0; exp_over = 1'b0;
    check("start_clr", clr, 1);
    check("start_wins", {wins_l, wins_r}, 0);
    check("start_over", match_over, 0);
  endtask

  task automatic wait_phase(input int rand_mode);
    int k;
    bit go, s, r;
    k = 0; go = 1'b0;
    for (int g = 0; g < 4000 && !go; g++) begin
      s = ($urandom_range(0, 2) == 0);
      case (rand_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = ($urandom_range(0, 5) == 0);
      endcase
      slowen = s; rand_bit = r;
      if (s) begin
        k++;
        if (k >= MAXW || (k >= MINW && r)) go = 1'b1;
      end
      @(negedge clk);
      check("wait_leds_winrnd", {leds_on, winrnd}, {go, 1'b0});
    end
    slowen = 1'b0; rand_bit = 1'b0;
  endtask

  task automatic push_phase(input int tl, input int tr);
    int t, last, diff;
    bit both, tie_e, right_e;
    t     = (tl < tr) ? tl : tr;
    both  = (tl < NEVER) && (tr < NEVER);
    diff  = (tl > tr) ? tl - tr : tr - tl;
    tie_e = both && (diff <= TW);
    right_e = !tie_e && (tr < tl);
    last  = t + TW + 1;
    for (int c = 0; c <= last + 1; c++) begin
      if (c == last && !tie_e) begin
        if (right_e) exp_wr = sat(exp_wr + 1);
        else         exp_wl = sat(exp_wl + 1);
      end
      check("go_leds", leds_on, (c <= t + TW));
      check("go_winrnd", winrnd, (c == last));
      if (c == last) begin
        check("rnd_right", right, right_e);
        check("rnd_tie", tie, tie_e);
        check("rnd_false_start", false_start, 0);
        check("rnd_wins_l", wins_l, exp_wl);
        check("rnd_wins_r", wins_r, exp_wr);
      end
      pbl_sy = (c >= tl);
      pbr_sy = (c >= tr);
      @(negedge clk);
    end
    pbl_sy = 1'b0; pbr_sy = 1'b0;
  endtask

  task automatic early_push(input int side, output bit ended);
    slowen = 1'b0;
    pbl_sy = side[0];
    pbr_sy = side[1];
    @(negedge clk);
    pbl_sy = 1'b0; pbr_sy = 1'b0;
`ifdef FALSE_START_EN
    ended = 1'b1;
    if (side == 1) exp_wr = sat(exp_wr + 1);
    if (side == 2) exp_wl = sat(exp_wl + 1);
    check("fs_winrnd", winrnd, 1);
    check("fs_flag", false_start, 1);
    check("fs_tie", tie, (side == 3));
    check("fs_right", right, (side == 1));
    check("fs_wins", {wins_l, wins_r}, {exp_wl[3:0], exp_wr[3:0]});
    @(negedge clk);
`else
    ended = 1'b0;
    check("early_ignored", {winrnd, leds_on, clr, false_start}, 0);
`endif
  endtask

  task automatic result_phase();
    int k;
    bit done, s;
    k = 0; done = 1'b0;
    for (int g = 0; g < 4000 && !done; g++) begin
      s = ($urandom_range(0, 2) == 0);
      slowen = s;
      start  = ($urandom_range(0, 9) == 0);
      pbl_sy = 1'($urandom_range(0, 1));
      pbr_sy = 1'($urandom_range(0, 1));
      if (s) begin
        k++;
        if (k == SHOW) done = 1'b1;
      end
      if (done) begin
        start = 1'b0; pbl_sy = 1'b0; pbr_sy = 1'b0;
      end
      @(negedge clk);
      if (!done) check("result_hold", {clr, match_over, winrnd, leds_on}, 0);
    end
    slowen = 1'b0; start = 1'b0; pbl_sy = 1'b0; pbr_sy = 1'b0;
    exp_over = (exp_wl == WR) || (exp_wr == WR);
    check("match_over", match_over, exp_over);
    check("next_clr", clr, !exp_over);
    if (exp_over) check("match_right", match_right, (exp_wr == WR));
  endtask

  task automatic play_round(input int rand_mode, input int pat, input int early, input int off);
    bit ended;
    int d, o;
    ended = 1'b0;
    if (early != 0) early_push(early, ended);
    if (!ended) begin
      wait_phase(rand_mode);
      d = $urandom_range(0, 5);
      o = (off != 0) ? off : $urandom_range(1, TW + 1);
      case (pat)
        0:       push_phase(d, NEVER);
        1:       push_phase(NEVER, d);
        2:       push_phase(d, d);
        3:       push_phase(d, d + o);
        default: push_phase(d + o, d);
      endcase
    end
    result_phase();
  endtask

  initial begin
    int rounds;
    rst = 1'b1;
    pbl_sy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", {clr, leds_on, winrnd, right, tie, false_start,
                         wins_l, wins_r, match_over, match_right}, 0);
    rst = 1'b0;
    pbl_sy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pbl_sy = i[0]; pbr_sy = ~i[0];
      @(negedge clk);
      check("idle_quiet", {clr, leds_on, winrnd}, 0);
    end
    pbl_sy = 1'b0; pbr_sy = 1'b0;
    @(negedge clk);

    do_start();
    play_round(0, 0, 0, 0);
    play_round(1, 3, 0, TW);
    play_round(1, 2, 0, 0);
    play_round(2, 1, 2, 0);
    rounds = 0;
    while (!exp_over && rounds < 40) begin
      play_round(2, $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 0);
      rounds++;
    end
    check("first_match_over", match_over, 1);

    for (int i = 0; i < 5; i++) begin
      pbl_sy = 1'($urandom_range(0, 1));
      pbr_sy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("end_hold", {match_over, wins_l, wins_r}, {1'b1, exp_wl[3:0], exp_wr[3:0]});
    end
    pbl_sy = 1'b0; pbr_sy = 1'b0;
    @(negedge clk);

    do_start();
    for (int i = 0; i < WR; i++) play_round(2, 1, 0, 0);
    check("right_match_wins", wins_r, WR);
    check("right_match_flag", {match_over, match_right}, 2'b11);

    do_start();
    wait_phase(1);
    pbl_sy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midround_reset", {clr, leds_on, winrnd, right, tie, false_start,
                             wins_l, wins_r, match_over, match_right}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_winrnd", {winrnd, leds_on, clr}, 0);
    end
    pbl_sy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
